audio_sample_writer: RTL and testbench

Consumer end of the sample hand-off into the audio codec path: accepts one-cycle `sample_valid` strobes carrying 16-bit samples from the sample-passing stage, buffers them in a small FIFO and drives the audio core's write handshake (`write_ready` / `write_audio_out`) with 24-bit left/right words. It sits between the sample hand-off stage and the DE1-SoC audio core, entirely in the 50 MHz domain.

---
 rtl/audio_pkg.sv | 27 ++
 rtl/sample_fifo.sv | 64 ++++++
 rtl/audio_sample_writer.sv | 95 +++++++++
 tb/tb_audio_sample_writer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio sample writer path.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Contents: writer_state_t FSM encoding, default widths, and widen_sample,
// which left-justifies a sample into a wider audio word.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    GAP   = 2'd3
  } writer_state_t;

  localparam int SAMPLE_W_DEF = 16;
  localparam int AUDIO_W_DEF  = 24;

  // Sample arrives zero-extended to 32 bits; shifting it up by the pad
  // width yields {sample, zeros} in the low AUDIO_W bits. The sign bit
  // lands in the audio word's MSB, so the scale is sign-preserving.
  function automatic logic [31:0] widen_sample(input logic [31:0] sample,
                                               input int unsigned pad_bits);
    return sample << pad_bits;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO holding samples between the hand-off stage and the writer FSM.
// Latency: push visible at dout/level one cycle after the push edge; dout is a combinational head read.
// Backpressure: a push while full is dropped unless a pop happens in the same cycle.
//
// Ports: clock50, reset (sync, active-high), push, pop, din -> dout (head),
// level (occupancy), full, empty. DEPTH must be a power of 2, at least 2.
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                       clock50,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_MASK = AW'(DEPTH - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign level = count;
  assign dout  = mem[rd_ptr];

  // A pop frees the slot in the same cycle, so a push into a full FIFO
  // is accepted when it coincides with a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock50) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr + 1'b1) & PTR_MASK;
      if (do_pop)  rd_ptr <= (rd_ptr + 1'b1) & PTR_MASK;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once the pointers say so.
  always_ff @(posedge clock50) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/audio_sample_writer.sv
// Buffers 16-bit sample strobes and writes them as 24-bit left/right words to the audio core.
// Latency: strobe at cycle 0 -> write_audio_out in cycle 3 (empty FIFO, write_ready high).
// Backpressure: holds data in WRITE while write_ready is low; full FIFO drops pushes and sets overflow.
//
// Ports: clock50, reset (sync, active-high), sample_in/sample_valid (push side),
// write_ready/write_audio_out/writedata_left/writedata_right (audio core side),
// fifo_level, overflow (sticky), underrun_cnt (saturating).
module audio_sample_writer
  import audio_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int AUDIO_W  = AUDIO_W_DEF,
  parameter int DEPTH    = 4
) (
  input  logic                     clock50,
  input  logic                     reset,
  input  logic [SAMPLE_W-1:0]      sample_in,
  input  logic                     sample_valid,
  input  logic                     write_ready,
  output logic                     write_audio_out,
  output logic [AUDIO_W-1:0]       writedata_left,
  output logic [AUDIO_W-1:0]       writedata_right,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [7:0]               underrun_cnt
);

  localparam int unsigned PAD_BITS = AUDIO_W - SAMPLE_W;

  writer_state_t       state;
  logic [SAMPLE_W-1:0] fifo_dout;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  logic [AUDIO_W-1:0]  head_word;

  // LOAD is only entered with a non-empty FIFO, so the pop never underflows.
  assign fifo_pop  = (state == LOAD);
  assign head_word = AUDIO_W'(widen_sample(32'(fifo_dout), PAD_BITS));

  // The one combinational input-to-output path: the core's ready is
  // echoed as the write strobe only while in WRITE.
  assign write_audio_out = (state == WRITE) && write_ready;

  sample_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clock50 (clock50),
    .reset   (reset),
    .push    (sample_valid),
    .pop     (fifo_pop),
    .din     (sample_in),
    .dout    (fifo_dout),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clock50) begin
    if (reset) begin
      state           <= IDLE;
      writedata_left  <= '0;
      writedata_right <= '0;
      overflow        <= 1'b0;
      underrun_cnt    <= '0;
    end else begin
      if (sample_valid && fifo_full && !fifo_pop) overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (write_ready) begin
            if (!fifo_empty) begin
              state <= LOAD;
            end else if (underrun_cnt != 8'hFF) begin
              underrun_cnt <= underrun_cnt + 8'd1;
            end
          end
        end
        LOAD: begin
          writedata_left  <= head_word;
          writedata_right <= head_word;
          state           <= WRITE;
        end
        WRITE: begin
          if (write_ready) state <= GAP;
        end
        // One dead cycle so the core can drop write_ready after a write.
        GAP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_sample_writer.sv
// Directed self-checking bench for audio_sample_writer (DEPTH=4, 16->24 bit).
// Latency: n/a.
// Backpressure: n/a.
module tb_audio_sample_writer;

  logic        clock50;
  logic        reset;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        write_ready;
  logic        write_audio_out;
  logic [23:0] writedata_left;
  logic [23:0] writedata_right;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic [7:0]  underrun_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  logic [23:0] got_q[$];
  int          dbl_strobes = 0;
  int          lr_diff     = 0;

  audio_sample_writer #(
    .SAMPLE_W (16),
    .AUDIO_W  (24),
    .DEPTH    (4)
  ) dut (
    .clock50         (clock50),
    .reset           (reset),
    .sample_in       (sample_in),
    .sample_valid    (sample_valid),
    .write_ready     (write_ready),
    .write_audio_out (write_audio_out),
    .writedata_left  (writedata_left),
    .writedata_right (writedata_right),
    .fifo_level      (fifo_level),
    .overflow        (overflow),
    .underrun_cnt    (underrun_cnt)
  );

  initial clock50 = 1'b0;
  always #5 clock50 = ~clock50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Move to the start of the next cycle (just after the rising edge).
  task automatic next_cycle();
    @(posedge clock50);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    sample_valid = 1'b0;
    sample_in    = '0;
    write_ready  = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  // Observe ncyc cycles, logging every write strobe and its data.
  task automatic run_collect(input int ncyc);
    logic prev;
    prev = 1'b0;
    got_q.delete();
    for (int i = 0; i < ncyc; i++) begin
      #2;
      if (write_audio_out) begin
        got_q.push_back(writedata_left);
        if (writedata_right !== writedata_left) lr_diff++;
        if (prev) dbl_strobes++;
      end
      prev = write_audio_out;
      next_cycle();
    end
  endtask

  initial begin
    logic        bp_bad;
    logic [23:0] exp_ovf [4];
    logic [23:0] exp_full[5];
    exp_ovf  = '{24'h000100, 24'h000200, 24'h000300, 24'h000400};
    exp_full = '{24'h000100, 24'h000200, 24'h000300, 24'h000400, 24'h000500};

    // ---- reset state ----
    do_reset();
    #2;
    check("rst_wao",   32'(write_audio_out), 32'd0);
    check("rst_left",  32'(writedata_left),  32'd0);
    check("rst_right", 32'(writedata_right), 32'd0);
    check("rst_level", 32'(fifo_level),      32'd0);
    check("rst_ovf",   32'(overflow),        32'd0);
    check("rst_undr",  32'(underrun_cnt),    32'd0);

    // ---- single sample, latency ----
    next_cycle();
    write_ready = 1'b1; sample_valid = 1'b1; sample_in = 16'h1234;   // cycle 0
    next_cycle();
    sample_valid = 1'b0; #2;                                          // cycle 1
    check("single_c1_level", 32'(fifo_level), 32'd1);
    check("single_c1_wao",   32'(write_audio_out), 32'd0);
    next_cycle(); #2;                                                 // cycle 2 LOAD
    check("single_c2_wao",   32'(write_audio_out), 32'd0);
    next_cycle(); #2;                                                 // cycle 3 WRITE
    check("single_c3_wao",   32'(write_audio_out), 32'd1);
    check("single_c3_left",  32'(writedata_left),  32'h123400);
    check("single_c3_right", 32'(writedata_right), 32'h123400);
    check("single_c3_level", 32'(fifo_level),      32'd0);
    next_cycle(); #2;                                                 // cycle 4 GAP
    check("single_c4_wao",   32'(write_audio_out), 32'd0);

    // ---- negative sample and back-pressure ----
    do_reset();
    sample_valid = 1'b1; sample_in = 16'h8001;
    next_cycle();
    sample_valid = 1'b0;
    bp_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #2;
      if (write_audio_out !== 1'b0 || fifo_level !== 3'd1) bp_bad = 1'b1;
      next_cycle();
    end
    check("bp_stay_idle", 32'(bp_bad), 32'd0);
    write_ready = 1'b1; #2;                                           // ready rises
    check("bp_r0_wao", 32'(write_audio_out), 32'd0);
    next_cycle(); #2;
    check("bp_r1_wao", 32'(write_audio_out), 32'd0);
    next_cycle(); #2;
    check("bp_r2_wao",   32'(write_audio_out), 32'd1);
    check("bp_r2_left",  32'(writedata_left),  32'h800100);
    check("bp_r2_right", 32'(writedata_right), 32'h800100);
    next_cycle();                                                     // GAP
    sample_valid = 1'b1; sample_in = 16'h7FFF; #2;
    check("bp_gap_wao", 32'(write_audio_out), 32'd0);
    next_cycle(); sample_valid = 1'b0;                                // IDLE
    next_cycle();                                                     // LOAD
    next_cycle(); write_ready = 1'b0; #2;                             // WRITE, ready low
    check("hold_w0_wao",  32'(write_audio_out), 32'd0);
    check("hold_w0_left", 32'(writedata_left),  32'h7FFF00);
    next_cycle(); #2;
    check("hold_w1_wao",  32'(write_audio_out), 32'd0);
    check("hold_w1_left", 32'(writedata_left),  32'h7FFF00);
    next_cycle(); write_ready = 1'b1; #2;
    check("hold_w2_wao",  32'(write_audio_out), 32'd1);
    check("hold_w2_left", 32'(writedata_left),  32'h7FFF00);
    next_cycle(); #2;
    check("hold_gap_wao", 32'(write_audio_out), 32'd0);

    // ---- overflow ----
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      sample_valid = 1'b1; sample_in = 16'(k);
      next_cycle();
    end
    sample_valid = 1'b0; #2;
    check("ovf_level", 32'(fifo_level), 32'd4);
    check("ovf_flag",  32'(overflow),   32'd1);
    next_cycle();
    write_ready = 1'b1;
    run_collect(40);
    check("ovf_nwrites", 32'(got_q.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < got_q.size()) check($sformatf("ovf_data%0d", k), 32'(got_q[k]), 32'(exp_ovf[k]));
    check("ovf_sticky", 32'(overflow), 32'd1);

    // ---- full with simultaneous push and pop ----
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      sample_valid = 1'b1; sample_in = 16'(k);
      next_cycle();
    end
    sample_valid = 1'b0; write_ready = 1'b1; #2;                      // IDLE -> LOAD
    check("full_level", 32'(fifo_level), 32'd4);
    next_cycle();
    sample_valid = 1'b1; sample_in = 16'd5;                           // LOAD pop + push
    next_cycle();
    sample_valid = 1'b0; #2;
    check("full_pp_level", 32'(fifo_level), 32'd4);
    check("full_pp_ovf",   32'(overflow),   32'd0);
    run_collect(40);
    check("full_nwrites", 32'(got_q.size()), 32'd5);
    for (int k = 0; k < 5; k++)
      if (k < got_q.size()) check($sformatf("full_data%0d", k), 32'(got_q[k]), 32'(exp_full[k]));
    check("full_end_level", 32'(fifo_level), 32'd0);

    // ---- underrun ----
    do_reset();
    write_ready = 1'b1;
    run_collect(100);
    #2;
    check("undr_100", 32'(underrun_cnt), 32'd100);
    next_cycle();
    run_collect(200);
    #2;
    check("undr_sat",     32'(underrun_cnt), 32'd255);
    check("undr_nwrites", 32'(got_q.size()), 32'd0);

    // ---- reset mid-WRITE ----
    do_reset();
    sample_valid = 1'b1; sample_in = 16'h0A0A; next_cycle();
    sample_valid = 1'b1; sample_in = 16'h0B0B; next_cycle();
    sample_valid = 1'b0; write_ready = 1'b1; next_cycle();            // IDLE -> LOAD
    write_ready = 1'b0; next_cycle(); #2;                             // WRITE, ready low
    check("rmw_wr_left", 32'(writedata_left), 32'h0A0A00);
    reset = 1'b1;
    next_cycle(); #2;
    check("rmw_left",  32'(writedata_left),  32'd0);
    check("rmw_right", 32'(writedata_right), 32'd0);
    check("rmw_level", 32'(fifo_level),      32'd0);
    check("rmw_wao",   32'(write_audio_out), 32'd0);
    reset = 1'b0; write_ready = 1'b1;
    next_cycle();
    run_collect(20);
    check("rmw_no_write", 32'(got_q.size()), 32'd0);
    sample_valid = 1'b1; sample_in = 16'h0C0C;
    next_cycle();
    sample_valid = 1'b0;
    run_collect(10);
    check("rmw_new_nwrites", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("rmw_new_data", 32'(got_q[0]), 32'h0C0C00);

    // ---- strobe shape across all collected windows ----
    check("never_double_strobe", 32'(dbl_strobes), 32'd0);
    check("left_eq_right",       32'(lr_diff),     32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
